// File: rtl/alu_cmd_driver_if.sv
// Bus bundle for alu_cmd_driver: command intake, ALU operand/result bus,
// result handshake and pass/fail counters.
interface alu_cmd_driver_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_code;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [1:0] alu_code;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [4:0] alu_c;
   logic       res_valid;
   logic       res_ready;
   logic [4:0] res_data;
   logic [1:0] res_code;
   logic       res_err;
   logic [7:0] pass_cnt;
   logic [7:0] fail_cnt;

   // Driver side
   modport master (
      input  cmd_valid, cmd_code, cmd_a, cmd_b, alu_c, res_ready,
      output cmd_ready, alu_code, alu_a, alu_b,
      output res_valid, res_data, res_code, res_err, pass_cnt, fail_cnt
   );

   // Environment side: command source, ALU and result consumer
   modport slave (
      output cmd_valid, cmd_code, cmd_a, cmd_b, alu_c, res_ready,
      input  cmd_ready, alu_code, alu_a, alu_b,
      input  res_valid, res_data, res_code, res_err, pass_cnt, fail_cnt
   );
endinterface

// File: rtl/alu_cmd_driver.sv
// ALU bus master: queues commands, drives them to the ALU one at a time,
// samples the result after SETTLE cycles and checks it against a golden model.
module alu_cmd_driver #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned SETTLE = 1
) (
   input logic             clk,
   input logic             rst_n,
   alu_cmd_driver_if.master bus
);
   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PTRW = PW + 1;
   localparam int unsigned CNTW = 4;
   localparam int unsigned RW   = 5;
   localparam int unsigned SCW  = 8;

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   typedef struct packed {
      logic [1:0] code;
      logic [3:0] a;
      logic [3:0] b;
   } cmd_t;

   state_t            state_q, state_d;
   cmd_t              mem_q [DEPTH];
   logic [PTRW-1:0]   wr_ptr_q, rd_ptr_q;
   cmd_t              alu_q, alu_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              res_valid_q, res_valid_d;
   logic [RW-1:0]     res_data_q, res_data_d;
   logic [1:0]        res_code_q, res_code_d;
   logic              res_err_q, res_err_d;
   logic [SCW-1:0]    pass_q, pass_d;
   logic [SCW-1:0]    fail_q, fail_d;
   logic              full, empty, push, pop;
   cmd_t              cmd_in;

   // Extra pointer MSB distinguishes full from empty
   assign full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign push   = bus.cmd_valid && !full;
   assign pop    = (state_q == IDLE) && !empty;
   assign cmd_in = '{code: bus.cmd_code, a: bus.cmd_a, b: bus.cmd_b};

   // Bit 4 is ignored for AND because the ALU leaves it unassigned
   function automatic logic golden_err(input cmd_t c, input logic [RW-1:0] r);
      logic [RW-1:0] a5, b5;
      a5 = {1'b0, c.a};
      b5 = {1'b0, c.b};
      case (c.code)
         2'b00:   golden_err = (r[3:0] != (c.a & c.b));
         2'b01:   golden_err = (r != (a5 | b5));
         2'b10:   golden_err = (r != RW'(a5 - b5));
         default: golden_err = (r != RW'(a5 + b5));
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[PW-1:0]] <= cmd_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         alu_q       <= '0;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_code_q  <= '0;
         res_err_q   <= 1'b0;
         pass_q      <= '0;
         fail_q      <= '0;
      end else begin
         state_q     <= state_d;
         alu_q       <= alu_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_code_q  <= res_code_d;
         res_err_q   <= res_err_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      alu_d       = alu_q;
      cnt_d       = cnt_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_code_d  = res_code_q;
      res_err_d   = res_err_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               alu_d   = mem_q[rd_ptr_q[PW-1:0]];
               cnt_d   = CNTW'(SETTLE);
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q <= CNTW'(1)) begin
               res_data_d  = bus.alu_c;
               res_code_d  = alu_q.code;
               res_err_d   = golden_err(alu_q, bus.alu_c);
               res_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         RESP: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               if (res_err_q) begin
                  if (fail_q != '1) fail_d = fail_q + SCW'(1);
               end else begin
                  if (pass_q != '1) pass_d = pass_q + SCW'(1);
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.cmd_ready = !full;
   assign bus.alu_code  = alu_q.code;
   assign bus.alu_a     = alu_q.a;
   assign bus.alu_b     = alu_q.b;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_code  = res_code_q;
   assign bus.res_err   = res_err_q;
   assign bus.pass_cnt  = pass_q;
   assign bus.fail_cnt  = fail_q;
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: SETTLE=1 instance with a behavioural ALU
// stub, plus a SETTLE=3 instance whose ALU result is driven by hand.
module tb_alu_cmd_driver;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   logic       ovr_en;
   logic [4:0] ovr_val;
   logic [4:0] or_mask;
   logic [4:0] alu_model;

   alu_cmd_driver_if bus ();
   alu_cmd_driver_if bus3 ();

   alu_cmd_driver #(.DEPTH(4), .SETTLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   alu_cmd_driver #(.DEPTH(4), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub ALU for the main instance; AND leaves bit 4 at 0 unless masked in
   always_comb begin
      case (bus.alu_code)
         2'b00:   alu_model = {1'b0, bus.alu_a & bus.alu_b};
         2'b01:   alu_model = {1'b0, bus.alu_a | bus.alu_b};
         2'b10:   alu_model = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
         default: alu_model = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      endcase
      bus.alu_c = ovr_en ? ovr_val : (alu_model | or_mask);
   end

   task automatic push_main(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
      bus.cmd_valid = 1'b1; bus.cmd_code = c; bus.cmd_a = a; bus.cmd_b = b;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic push3(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
      bus3.cmd_valid = 1'b1; bus3.cmd_code = c; bus3.cmd_a = a; bus3.cmd_b = b;
      @(posedge clk); #1;
      bus3.cmd_valid = 1'b0;
   endtask

   // Bounded wait for a result on the main instance
   task automatic wait_result(input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.res_valid) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s: res_valid=0 after 20 cycles, required 1", name);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
      checks++; if ({bus.alu_code, bus.alu_a, bus.alu_b} !== 10'h0) begin errors++; $display("FAIL reset_alu: got %h want 0", {bus.alu_code, bus.alu_a, bus.alu_b}); end
      checks++; if ({bus.res_data, bus.res_code, bus.res_err} !== 8'h0) begin errors++; $display("FAIL reset_res: got %h want 0", {bus.res_data, bus.res_code, bus.res_err}); end
      checks++; if ({bus.pass_cnt, bus.fail_cnt} !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", {bus.pass_cnt, bus.fail_cnt}); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      bus.res_ready = 1'b1;
      push_main(2'b11, 4'hF, 4'h1);
      @(posedge clk); #1;
      checks++; if ({bus.alu_code, bus.alu_a, bus.alu_b} !== {2'b11, 4'hF, 4'h1}) begin errors++; $display("FAIL add_alu_bus: got %h want %h", {bus.alu_code, bus.alu_a, bus.alu_b}, {2'b11, 4'hF, 4'h1}); end
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b want 0", bus.res_valid); end
      @(posedge clk); #1;
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", bus.res_valid); end
      checks++; if ({bus.res_data, bus.res_code, bus.res_err} !== {5'h10, 2'b11, 1'b0}) begin errors++; $display("FAIL add_result: got %h want %h", {bus.res_data, bus.res_code, bus.res_err}, {5'h10, 2'b11, 1'b0}); end
      @(posedge clk); #1;
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL add_valid_drop: got %b want 0", bus.res_valid); end
      checks++; if (bus.pass_cnt !== 8'd1) begin errors++; $display("FAIL add_pass_cnt: got %0d want 1", bus.pass_cnt); end
   endtask

   task automatic test_sub_and();
      or_mask = 5'h10;
      push_main(2'b10, 4'h3, 4'h5);
      push_main(2'b00, 4'hC, 4'hA);
      wait_result("sub_wait");
      checks++; if ({bus.res_data, bus.res_code, bus.res_err} !== {5'h1E, 2'b10, 1'b0}) begin errors++; $display("FAIL sub_result: got %h want %h", {bus.res_data, bus.res_code, bus.res_err}, {5'h1E, 2'b10, 1'b0}); end
      wait_result("and_wait");
      checks++; if ({bus.res_data, bus.res_code, bus.res_err} !== {5'h18, 2'b00, 1'b0}) begin errors++; $display("FAIL and_result: got %h want %h", {bus.res_data, bus.res_code, bus.res_err}, {5'h18, 2'b00, 1'b0}); end
      @(posedge clk); #1;
      checks++; if (bus.pass_cnt !== 8'd3) begin errors++; $display("FAIL sub_and_pass_cnt: got %0d want 3", bus.pass_cnt); end
      or_mask = 5'h00;
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_d [4] = '{5'h0F, 5'h01, 5'h06, 5'h1E};
      logic [1:0] exp_c [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
      bus.res_ready = 1'b0;
      push_main(2'b11, 4'h1, 4'h1);
      push_main(2'b01, 4'h5, 4'hA);
      push_main(2'b10, 4'h2, 4'h1);
      push_main(2'b00, 4'hF, 4'h6);
      push_main(2'b11, 4'hF, 4'hF);
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: cmd_ready got %b want 0", bus.cmd_ready); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_hold: cmd_ready got %b want 0", bus.cmd_ready); end
      checks++; if ({bus.res_valid, bus.res_data, bus.res_code} !== {1'b1, 5'h02, 2'b11}) begin errors++; $display("FAIL b2b_first: got %h want %h", {bus.res_valid, bus.res_data, bus.res_code}, {1'b1, 5'h02, 2'b11}); end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if ({bus.res_valid, bus.cmd_ready} !== 2'b00) begin errors++; $display("FAIL b2b_after_hs: valid,ready got %b want 00", {bus.res_valid, bus.cmd_ready}); end
      @(posedge clk); #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_return: got %b want 1", bus.cmd_ready); end
      for (int i = 0; i < 4; i++) begin
         wait_result("b2b_wait");
         checks++;
         if ({bus.res_data, bus.res_code, bus.res_err} !== {exp_d[i], exp_c[i], 1'b0}) begin
            errors++;
            $display("FAIL b2b_result%0d: got %h want %h", i + 1, {bus.res_data, bus.res_code, bus.res_err}, {exp_d[i], exp_c[i], 1'b0});
         end
      end
      @(posedge clk); #1;
      checks++; if (bus.pass_cnt !== 8'd8) begin errors++; $display("FAIL b2b_pass_cnt: got %0d want 8", bus.pass_cnt); end
   endtask

   task automatic test_fail_hold();
      bus.res_ready = 1'b0;
      ovr_en  = 1'b1;
      ovr_val = 5'h00;
      push_main(2'b01, 4'h1, 4'h2);
      wait_result("fail_wait");
      checks++; if ({bus.res_data, bus.res_code, bus.res_err} !== {5'h00, 2'b01, 1'b1}) begin errors++; $display("FAIL fail_result: got %h want %h", {bus.res_data, bus.res_code, bus.res_err}, {5'h00, 2'b01, 1'b1}); end
      ovr_val = 5'h1F;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({bus.res_valid, bus.res_data, bus.res_code, bus.res_err} !== {1'b1, 5'h00, 2'b01, 1'b1}) begin
            errors++;
            $display("FAIL fail_hold%0d: got %h want %h", i, {bus.res_valid, bus.res_data, bus.res_code, bus.res_err}, {1'b1, 5'h00, 2'b01, 1'b1});
         end
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL fail_valid_drop: got %b want 0", bus.res_valid); end
      checks++; if ({bus.fail_cnt, bus.pass_cnt} !== {8'd1, 8'd8}) begin errors++; $display("FAIL fail_counters: fail,pass got %0d,%0d want 1,8", bus.fail_cnt, bus.pass_cnt); end
      ovr_en = 1'b0;
   endtask

   task automatic test_settle3();
      bus3.res_ready = 1'b1;
      push3(2'b11, 4'h2, 4'h3);
      @(posedge clk); #1;
      bus3.alu_c = 5'h1F;
      checks++; if ({bus3.alu_code, bus3.alu_a, bus3.alu_b} !== {2'b11, 4'h2, 4'h3}) begin errors++; $display("FAIL s3_alu_bus: got %h want %h", {bus3.alu_code, bus3.alu_a, bus3.alu_b}, {2'b11, 4'h2, 4'h3}); end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         bus3.alu_c = (i == 0) ? 5'h1E : 5'h05;
         checks++;
         if ({bus3.res_valid, bus3.alu_code, bus3.alu_a, bus3.alu_b} !== {1'b0, 2'b11, 4'h2, 4'h3}) begin
            errors++;
            $display("FAIL s3_hold%0d: got %h want %h", i, {bus3.res_valid, bus3.alu_code, bus3.alu_a, bus3.alu_b}, {1'b0, 2'b11, 4'h2, 4'h3});
         end
      end
      @(posedge clk); #1;
      checks++; if ({bus3.res_valid, bus3.res_data, bus3.res_err} !== {1'b1, 5'h05, 1'b0}) begin errors++; $display("FAIL s3_result: got %h want %h", {bus3.res_valid, bus3.res_data, bus3.res_err}, {1'b1, 5'h05, 1'b0}); end
      @(posedge clk); #1;
      checks++; if (bus3.pass_cnt !== 8'd1) begin errors++; $display("FAIL s3_pass_cnt: got %0d want 1", bus3.pass_cnt); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      push3(2'b11, 4'h1, 4'h1);
      push3(2'b11, 4'h4, 4'h4);
      push3(2'b01, 4'h2, 4'h2);
      checks++; if (bus3.alu_a !== 4'h1) begin errors++; $display("FAIL rmid_pre_drive: alu_a got %h want 1", bus3.alu_a); end
      rst_n = 1'b0;
      #1;
      checks++; if ({bus3.alu_code, bus3.alu_a, bus3.alu_b, bus3.res_valid} !== 11'h0) begin errors++; $display("FAIL rmid_async_zero: got %h want 0", {bus3.alu_code, bus3.alu_a, bus3.alu_b, bus3.res_valid}); end
      checks++; if ({bus3.pass_cnt, bus.pass_cnt, bus.fail_cnt} !== 24'h0) begin errors++; $display("FAIL rmid_cnt_zero: got %h want 0", {bus3.pass_cnt, bus.pass_cnt, bus.fail_cnt}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (bus3.res_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_result: res_valid seen %b want 0", seen); end
      checks++; if (bus3.cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", bus3.cmd_ready); end
      checks++; if ({bus3.alu_a, bus3.pass_cnt, bus3.fail_cnt} !== 20'h0) begin errors++; $display("FAIL rmid_empty: got %h want 0", {bus3.alu_a, bus3.pass_cnt, bus3.fail_cnt}); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      ovr_en = 1'b0; ovr_val = 5'h00; or_mask = 5'h00;
      bus.cmd_valid = 1'b0; bus.cmd_code = 2'b00; bus.cmd_a = 4'h0; bus.cmd_b = 4'h0;
      bus.res_ready = 1'b0;
      bus3.cmd_valid = 1'b0; bus3.cmd_code = 2'b00; bus3.cmd_a = 4'h0; bus3.cmd_b = 4'h0;
      bus3.res_ready = 1'b0; bus3.alu_c = 5'h00;
      test_reset();
      test_add();
      test_sub_and();
      test_back_to_back();
      test_fail_hold();
      test_settle3();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
